sdram_arb: RTL and testbench
============================

Name: sdram_arb

Overview:
Command scheduler in front of the SDRAM command FSM. It shares the single SDRAM command path between the periodic auto-refresh timer, the write requester (`sdram_wr_req`/`sdram_wr_ack`) and the read requester (`sdram_rd_req`/`sdram_rd_ack`) of the data block. It grants one operation at a time, pulses the matching start strobe to the command FSM, and holds the grant until that FSM reports end of operation. A watchdog and a refresh-overrun monitor report error conditions.

Parameters:
REF_CYCLES, 780, clk cycles between refresh requests (7.8 us at 100 MHz); legal range 2 .. 2^CNT_W-1
TIMEOUT, 1023, maximum cycles in any busy state before the watchdog fires; legal range 2 .. 2^CNT_W-1
CNT_W, 16, width of the refresh and watchdog counters

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
init_done  in  1  level; SDRAM power-up init complete
sdram_rd_req  in  1  read request; held until ack
sdram_rd_ack  out  1  one-cycle read grant
sdram_wr_req  in  1  write request; held until ack
sdram_wr_ack  out  1  one-cycle write grant
aref_start  out  1  one-cycle pulse: issue auto-refresh
rd_start  out  1  one-cycle pulse: issue read burst
wr_start  out  1  one-cycle pulse: issue write burst
end_tref  in  1  pulse: refresh sequence finished
end_tread  in  1  pulse: read burst finished
end_twrite  in  1  pulse: write burst finished
busy  out  1  high in any busy state
cur_grant  out  2  0 none, 1 refresh, 2 write, 3 read
ref_overrun  out  1  sticky: refresh period expired while a refresh was still pending
err_timeout  out  1  sticky: watchdog fired
clr_err  in  1  clears both sticky flags

Behaviour:
- All outputs are registered. Reset is synchronous: `rst` high at a clock edge forces state=WAIT_INIT, all counters 0, `ref_pend`=0, and every output 0. Reset mid-operation abandons the grant with no end-of-operation pulse; the requesters are reset by the same signal.
- States: WAIT_INIT, ARB, REF, WR, RD.
- WAIT_INIT: go to ARB when `init_done`=1. The refresh counter is held at 0 in this state.
- Refresh timer, active outside WAIT_INIT:
  - Counts 0..REF_CYCLES-1 and wraps.
  - On wrap, set `ref_pend`.
  - If `ref_pend` is already 1 at wrap, set `ref_overrun`.
  - `ref_pend` clears on the edge that moves the FSM to REF. If that edge coincides with a wrap, `ref_pend` stays 1 and no overrun is flagged.
- ARB, decided at each edge, with fixed priority:
  1. `ref_pend` -> REF; pulse `aref_start`.
  2. Only one of wr/rd requesting -> grant it.
  3. Both requesting -> round-robin: grant the one not granted last. After reset, last=read, so the write wins first.
  - A write grant goes to WR with `wr_start` and `sdram_wr_ack` high for the next cycle only. Read is symmetric with RD, `rd_start` and `sdram_rd_ack`.
  - No request and no `ref_pend`: stay in ARB.
- Grant latency: a request sampled high in ARB at edge N gives ack/start high during cycle N to N+1. There is exactly one ack per request.
- REF/WR/RD: wait for the matching `end_*` pulse, then return to ARB. At least one ARB cycle always separates two grants. `end_*` pulses that do not match the current state are ignored.
- Watchdog:
  - Cleared on entry to any busy state; increments each busy cycle.
  - When it reaches TIMEOUT-1: set `err_timeout` and force ARB.
  - A timed-out refresh does not re-set `ref_pend`. A timed-out request is not re-acked.
- `busy` is 1 in REF/WR/RD. `cur_grant` encodes the current state and is 0 in ARB/WAIT_INIT.
- `clr_err` clears both sticky flags. If a new error event occurs on the same edge, the set wins.
- If `init_done` drops, it is ignored after WAIT_INIT; only `rst` returns the block there.

Test Plan:
- Reset and init: hold `rst`, then `init_done`=0 for 50 cycles -> all outputs 0, no `aref_start`. Raise `init_done` -> first `aref_start` 781 cycles later (±1 for the ARB cycle), `cur_grant`=1 until `end_tref`.
- Single read: `sdram_rd_req`=1 in ARB -> `sdram_rd_ack` and `rd_start` high exactly one cycle, next cycle after sample. `busy`=1, `cur_grant`=3 until `end_tread`, then ARB for at least 1 cycle.
- Contention: `sdram_wr_req` and `sdram_rd_req` both held continuously, end pulses 8 cycles after each start -> grants alternate W,R,W,R starting with W; no requester acked twice in a row.
- Refresh priority and overrun: `ref_pend` raised while a write is busy, read pending -> after `end_twrite` the next grant is refresh, not read. With REF_CYCLES=20 and `end_tref` withheld past two wraps -> `ref_overrun`=1, stays 1 until `clr_err`.
- Watchdog: TIMEOUT=16, grant a read, never pulse `end_tread` -> `err_timeout` set after 16 busy cycles, FSM back in ARB, no second `sdram_rd_ack`. `clr_err` pulse clears it.
- Reset mid-burst: assert `rst` during WR -> next cycle `busy`=0, `cur_grant`=0, state WAIT_INIT, refresh counter 0.

Source files
------------

// File: rtl/sdram_arb_if.sv
// Command-scheduler bus: requester handshakes, command-FSM strobes,
// end-of-operation pulses and status/error flags.
interface sdram_arb_if;
  logic       init_done;
  logic       sdram_rd_req;
  logic       sdram_rd_ack;
  logic       sdram_wr_req;
  logic       sdram_wr_ack;
  logic       aref_start;
  logic       rd_start;
  logic       wr_start;
  logic       end_tref;
  logic       end_tread;
  logic       end_twrite;
  logic       busy;
  logic [1:0] cur_grant;
  logic       ref_overrun;
  logic       err_timeout;
  logic       clr_err;

  modport slave (
    input  init_done, sdram_rd_req, sdram_wr_req, end_tref, end_tread, end_twrite, clr_err,
    output sdram_rd_ack, sdram_wr_ack, aref_start, rd_start, wr_start, busy, cur_grant,
           ref_overrun, err_timeout
  );

  modport master (
    output init_done, sdram_rd_req, sdram_wr_req, end_tref, end_tread, end_twrite, clr_err,
    input  sdram_rd_ack, sdram_wr_ack, aref_start, rd_start, wr_start, busy, cur_grant,
           ref_overrun, err_timeout
  );
endinterface

// File: rtl/sdram_arb.sv
// SDRAM command scheduler: shares one command path between the refresh
// timer and the write/read requesters, one operation at a time.
module sdram_arb #(
  parameter int REF_CYCLES = 780,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  sdram_arb_if.slave  bus
);

  typedef enum logic [2:0] {WAIT_INIT, ARB, REF, WR, RD} state_t;

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ref_cnt, wd_cnt, wd_nxt;
  logic             ref_pend, last_rd, last_rd_nxt;
  logic             wrap, go_ref, op_done, timeout;
  logic             aref_nxt, wr_nxt, rd_nxt, busy_nxt;
  logic [1:0]       grant_nxt;

  // Refresh timer only runs once init is done.
  assign wrap    = (state != WAIT_INIT) && (ref_cnt == REF_LAST);
  assign op_done = (state == REF && bus.end_tref) ||
                   (state == WR  && bus.end_twrite) ||
                   (state == RD  && bus.end_tread);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_INIT;
    else     state <= state_nxt;
  end

  // Next state, grant decision and watchdog
  always_comb begin
    state_nxt   = state;
    wd_nxt      = wd_cnt;
    last_rd_nxt = last_rd;
    go_ref      = 1'b0;
    timeout     = 1'b0;
    aref_nxt    = 1'b0;
    wr_nxt      = 1'b0;
    rd_nxt      = 1'b0;
    case (state)
      WAIT_INIT: if (bus.init_done) state_nxt = ARB;
      ARB: begin
        // Watchdog restarts on every grant; ARB itself is never timed.
        wd_nxt = '0;
        if (ref_pend) begin
          go_ref    = 1'b1;
          aref_nxt  = 1'b1;
          state_nxt = REF;
        end else if (bus.sdram_wr_req && (!bus.sdram_rd_req || last_rd)) begin
          wr_nxt      = 1'b1;
          last_rd_nxt = 1'b0;
          state_nxt   = WR;
        end else if (bus.sdram_rd_req) begin
          rd_nxt      = 1'b1;
          last_rd_nxt = 1'b1;
          state_nxt   = RD;
        end
      end
      REF, WR, RD: begin
        // A real completion beats a timeout on the same edge.
        if (op_done) begin
          state_nxt = ARB;
        end else if (wd_cnt == WD_LAST) begin
          timeout   = 1'b1;
          state_nxt = ARB;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_INIT;
    endcase
    busy_nxt = (state_nxt == REF) || (state_nxt == WR) || (state_nxt == RD);
    case (state_nxt)
      REF:     grant_nxt = 2'd1;
      WR:      grant_nxt = 2'd2;
      RD:      grant_nxt = 2'd3;
      default: grant_nxt = 2'd0;
    endcase
  end

  // Refresh timer, pending refresh, watchdog counter, round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
      wd_cnt   <= '0;
      last_rd  <= 1'b1;   // write wins the first contention
    end else begin
      ref_cnt <= (state == WAIT_INIT || wrap) ? '0 : ref_cnt + 1'b1;
      // A wrap on the grant edge keeps the request alive for the next period.
      if (wrap)        ref_pend <= 1'b1;
      else if (go_ref) ref_pend <= 1'b0;
      wd_cnt  <= wd_nxt;
      last_rd <= last_rd_nxt;
    end
  end

  // Registered outputs and sticky error flags (set wins over clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.aref_start   <= 1'b0;
      bus.wr_start     <= 1'b0;
      bus.rd_start     <= 1'b0;
      bus.sdram_wr_ack <= 1'b0;
      bus.sdram_rd_ack <= 1'b0;
      bus.busy         <= 1'b0;
      bus.cur_grant    <= 2'd0;
      bus.ref_overrun  <= 1'b0;
      bus.err_timeout  <= 1'b0;
    end else begin
      bus.aref_start   <= aref_nxt;
      bus.wr_start     <= wr_nxt;
      bus.rd_start     <= rd_nxt;
      bus.sdram_wr_ack <= wr_nxt;
      bus.sdram_rd_ack <= rd_nxt;
      bus.busy         <= busy_nxt;
      bus.cur_grant    <= grant_nxt;
      if (wrap && ref_pend && !go_ref) bus.ref_overrun <= 1'b1;
      else if (bus.clr_err)            bus.ref_overrun <= 1'b0;
      if (timeout)          bus.err_timeout <= 1'b1;
      else if (bus.clr_err) bus.err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: dut_a (long refresh period, short watchdog)
// covers init, grants, contention, watchdog and reset; dut_b (short refresh
// period, long watchdog) covers refresh priority and overrun.
module tb_sdram_arb;
  localparam int REF_A = 780, TO_A = 16;
  localparam int REF_B = 20,  TO_B = 100;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  int   checks = 0, failures = 0, cyc = 0;

  sdram_arb_if a();
  sdram_arb_if b();

  sdram_arb #(.REF_CYCLES(REF_A), .TIMEOUT(TO_A), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(a.slave));
  sdram_arb #(.REF_CYCLES(REF_B), .TIMEOUT(TO_B), .CNT_W(16)) dut_b (.clk(clk), .rst(rst_b), .bus(b.slave));

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic init_inputs();
    a.init_done = 0; a.sdram_rd_req = 0; a.sdram_wr_req = 0; a.clr_err = 0;
    a.end_tref = 0; a.end_tread = 0; a.end_twrite = 0;
    b.init_done = 0; b.sdram_rd_req = 0; b.sdram_wr_req = 0; b.clr_err = 0;
    b.end_tref = 0; b.end_tread = 0; b.end_twrite = 0;
  endtask

  task automatic test_reset();
    int bad;
    logic [9:0] outs;
    rst_a = 1;
    repeat (3) tick();
    outs = {a.busy, a.cur_grant, a.aref_start, a.rd_start, a.wr_start,
            a.sdram_rd_ack, a.sdram_wr_ack, a.ref_overrun, a.err_timeout};
    checks++; if (outs !== 10'h0) begin failures++; $display("FAIL reset_outputs: got %h expected 000", outs); end
    rst_a = 0;
    bad = 0;
    repeat (50) begin
      tick();
      if (a.aref_start || a.busy || a.cur_grant != 2'd0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL wait_init_idle: got %0d active cycles expected 0", bad); end
  endtask

  // init_done edge is tick 1; wrap at the 781st edge, grant on the 782nd.
  task automatic test_init_refresh();
    int n;
    logic seen;
    a.init_done = 1;
    n = 0; seen = 0;
    while (!seen && n < 1000) begin tick(); n++; if (a.aref_start) seen = 1; end
    checks++; if (n !== 782) begin failures++; $display("FAIL first_refresh_latency: got %0d expected 782", n); end
    checks++; if ({a.busy, a.cur_grant} !== 3'b1_01) begin failures++; $display("FAIL refresh_grant: got %b expected 101", {a.busy, a.cur_grant}); end
    tick();
    checks++; if ({a.aref_start, a.cur_grant} !== 3'b0_01) begin failures++; $display("FAIL refresh_hold: got %b expected 001", {a.aref_start, a.cur_grant}); end
    a.end_tref = 1; tick(); a.end_tref = 0;
    checks++; if ({a.busy, a.cur_grant} !== 3'b0_00) begin failures++; $display("FAIL refresh_end: got %b expected 000", {a.busy, a.cur_grant}); end
  endtask

  task automatic test_single_read();
    a.sdram_rd_req = 1; tick();
    checks++; if ({a.sdram_rd_ack, a.rd_start, a.sdram_wr_ack, a.cur_grant, a.busy} !== 6'b1_1_0_11_1) begin
      failures++; $display("FAIL read_grant: got %b expected 110111", {a.sdram_rd_ack, a.rd_start, a.sdram_wr_ack, a.cur_grant, a.busy}); end
    a.sdram_rd_req = 0; tick();
    checks++; if ({a.sdram_rd_ack, a.rd_start, a.cur_grant} !== 4'b0_0_11) begin
      failures++; $display("FAIL read_pulse_width: got %b expected 0011", {a.sdram_rd_ack, a.rd_start, a.cur_grant}); end
    a.end_twrite = 1; a.end_tref = 1; tick(); a.end_twrite = 0; a.end_tref = 0;
    checks++; if (a.cur_grant !== 2'd3) begin failures++; $display("FAIL read_ignores_other_end: got %0d expected 3", a.cur_grant); end
    a.end_tread = 1; tick(); a.end_tread = 0;
    checks++; if ({a.busy, a.cur_grant} !== 3'b0_00) begin failures++; $display("FAIL read_end: got %b expected 000", {a.busy, a.cur_grant}); end
    tick();
    checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL idle_arb: got %b expected 0", a.busy); end
  endtask

  task automatic test_contention();
    logic exp_wr;
    int extra;
    extra = 0;
    a.sdram_wr_req = 1; a.sdram_rd_req = 1;
    for (int g = 0; g < 4; g++) begin
      tick();
      exp_wr = (g % 2 == 0);
      checks++; if ({a.sdram_wr_ack, a.sdram_rd_ack} !== {exp_wr, ~exp_wr}) begin
        failures++; $display("FAIL rr_grant%0d: got wr/rd=%b expected %b", g, {a.sdram_wr_ack, a.sdram_rd_ack}, {exp_wr, ~exp_wr}); end
      repeat (7) begin tick(); if (a.sdram_wr_ack || a.sdram_rd_ack) extra++; end
      if (exp_wr) a.end_twrite = 1; else a.end_tread = 1;
      tick();
      a.end_twrite = 0; a.end_tread = 0;
      if (g == 3) begin a.sdram_wr_req = 0; a.sdram_rd_req = 0; end
      checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL rr_arb_gap%0d: got busy=%b expected 0", g, a.busy); end
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL rr_extra_acks: got %0d expected 0", extra); end
  endtask

  // Grant edge G; watchdog reaches TIMEOUT-1 after G+15 and fires at G+16.
  task automatic test_watchdog();
    int extra;
    a.sdram_rd_req = 1; tick();
    checks++; if (a.sdram_rd_ack !== 1'b1) begin failures++; $display("FAIL wd_grant: got %b expected 1", a.sdram_rd_ack); end
    a.sdram_rd_req = 0;
    repeat (15) tick();
    checks++; if ({a.err_timeout, a.busy} !== 2'b01) begin failures++; $display("FAIL wd_before: got %b expected 01", {a.err_timeout, a.busy}); end
    tick();
    checks++; if ({a.err_timeout, a.busy, a.cur_grant} !== 4'b1_0_00) begin
      failures++; $display("FAIL wd_fire: got %b expected 1000", {a.err_timeout, a.busy, a.cur_grant}); end
    extra = 0;
    repeat (5) begin tick(); if (a.sdram_rd_ack) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL wd_no_reack: got %0d expected 0", extra); end
    a.clr_err = 1; tick(); a.clr_err = 0;
    checks++; if (a.err_timeout !== 1'b0) begin failures++; $display("FAIL wd_clear: got %b expected 0", a.err_timeout); end
  endtask

  task automatic test_reset_mid_burst();
    int n, extra;
    logic seen;
    a.sdram_wr_req = 1; tick();
    checks++; if (a.sdram_wr_ack !== 1'b1) begin failures++; $display("FAIL mid_wr_grant: got %b expected 1", a.sdram_wr_ack); end
    a.sdram_wr_req = 0;
    tick(); tick();
    rst_a = 1; tick();
    checks++; if ({a.busy, a.cur_grant, a.wr_start} !== 4'b0) begin
      failures++; $display("FAIL mid_reset: got %b expected 0000", {a.busy, a.cur_grant, a.wr_start}); end
    a.init_done = 0; rst_a = 0; a.sdram_rd_req = 1;
    extra = 0;
    repeat (5) begin tick(); if (a.sdram_rd_ack || a.busy) extra++; end
    checks++; if (extra !== 0) begin failures++; $display("FAIL wait_init_blocks: got %0d expected 0", extra); end
    a.sdram_rd_req = 0; a.init_done = 1;
    n = 0; seen = 0;
    while (!seen && n < 1000) begin tick(); n++; if (a.aref_start) seen = 1; end
    checks++; if (n !== 782) begin failures++; $display("FAIL refresh_after_reset: got %0d expected 782", n); end
    a.end_tref = 1; tick(); a.end_tref = 0;
    a.init_done = 0; tick();
    a.sdram_rd_req = 1; tick();
    checks++; if (a.sdram_rd_ack !== 1'b1) begin failures++; $display("FAIL init_drop_ignored: got %b expected 1", a.sdram_rd_ack); end
    a.sdram_rd_req = 0;
    a.end_tread = 1; tick(); a.end_tread = 0;
  endtask

  // Edge numbers relative to the init edge E0: wraps at E20, E40, E60, E80, E100.
  task automatic test_refresh_overrun();
    int base;
    b.init_done = 1; rst_b = 0;
    tick(); base = cyc;
    while (cyc - base < 21) tick();
    checks++; if (b.aref_start !== 1'b1) begin failures++; $display("FAIL b_first_refresh: got %b expected 1", b.aref_start); end
    while (cyc - base < 23) tick();
    b.end_tref = 1; tick(); b.end_tref = 0;
    b.sdram_wr_req = 1; tick();
    checks++; if (b.sdram_wr_ack !== 1'b1) begin failures++; $display("FAIL b_wr_grant: got %b expected 1", b.sdram_wr_ack); end
    b.sdram_wr_req = 0; b.sdram_rd_req = 1;
    while (cyc - base < 41) tick();
    b.end_twrite = 1; tick(); b.end_twrite = 0;
    checks++; if (b.busy !== 1'b0) begin failures++; $display("FAIL b_wr_end: got %b expected 0", b.busy); end
    tick();
    checks++; if ({b.aref_start, b.sdram_rd_ack, b.cur_grant} !== 4'b1_0_01) begin
      failures++; $display("FAIL refresh_priority: got %b expected 1001", {b.aref_start, b.sdram_rd_ack, b.cur_grant}); end
    while (cyc - base < 79) tick();
    checks++; if (b.ref_overrun !== 1'b0) begin failures++; $display("FAIL overrun_early: got %b expected 0", b.ref_overrun); end
    tick();
    checks++; if (b.ref_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b expected 1", b.ref_overrun); end
    tick();
    b.end_tref = 1; tick(); b.end_tref = 0;
    tick();
    checks++; if ({b.aref_start, b.cur_grant} !== 3'b1_01) begin failures++; $display("FAIL pending_refresh_again: got %b expected 101", {b.aref_start, b.cur_grant}); end
    tick();
    b.end_tref = 1; tick(); b.end_tref = 0;
    tick();
    checks++; if (b.sdram_rd_ack !== 1'b1) begin failures++; $display("FAIL b_rd_grant: got %b expected 1", b.sdram_rd_ack); end
    b.sdram_rd_req = 0;
    tick();
    b.end_tread = 1; tick(); b.end_tread = 0;
    checks++; if (b.ref_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b expected 1", b.ref_overrun); end
    b.clr_err = 1; tick(); b.clr_err = 0;
    checks++; if ({b.ref_overrun, b.err_timeout} !== 2'b00) begin failures++; $display("FAIL overrun_clear: got %b expected 00", {b.ref_overrun, b.err_timeout}); end
  endtask

  initial begin
    init_inputs();
    repeat (2) tick();
    test_reset();
    test_init_refresh();
    test_single_read();
    test_contention();
    test_watchdog();
    test_reset_mid_burst();
    test_refresh_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
